// File: rtl/uart_tx_ctrl.sv
// UART transmit path: a valid/ready write port fills a small synchronous FIFO which
// a frame serialiser drains onto tx_o, one bit per external baud-rate enable pulse.
module uart_tx_ctrl #(
    parameter int DLY        = 1,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic [1:0]            stop_bits,
    input  logic                  br_en_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_vld_i,
    output logic                  tx_rdy_o,
    output logic                  tx_fifo_full_o,
    output logic                  tx_fifo_empty_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o,
    output logic                  tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Register updates are zero-delay; DLY stays so existing instantiations still elaborate.
    localparam int unused_dly = DLY;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic [31:0]           db_ext;
    logic [CW-1:0]         cfg_nbits;
    logic [DATA_WIDTH-1:0] cfg_mask;
    logic                  cfg_par_en;
    logic                  cfg_par_bit;
    logic                  cfg_two_stop;

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [CW-1:0]         bit_cnt_q,  bit_cnt_d;
    logic [CW-1:0]         nbits_q,    nbits_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q;
    logic                  done_c;

    assign tx_fifo_full_o  = (count == (AW + 1)'(FIFO_DEPTH));
    assign tx_fifo_empty_o = (count == '0);
    assign tx_rdy_o        = ~tx_fifo_full_o;
    assign push            = tx_vld_i & tx_rdy_o;
    assign fifo_head       = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame format as it would apply to a frame starting now; latched only at pop time.
    assign db_ext = {28'd0, data_bits};

    always_comb begin
        if (db_ext >= 32'd5 && db_ext <= 32'(DATA_WIDTH)) begin
            cfg_nbits = db_ext[CW-1:0];
        end else begin
            cfg_nbits = CW'(DATA_WIDTH);
        end
    end

    assign cfg_mask     = ~({DATA_WIDTH{1'b1}} << cfg_nbits);
    assign cfg_par_en   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign cfg_par_bit  = (^(fifo_head & cfg_mask)) ^ (parity_mode == 2'b01);
    assign cfg_two_stop = (stop_bits != 2'b00);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        done_c     = 1'b0;

        if (br_en_i) begin
            case (state_q)
                IDLE: begin
                    pop = ~tx_fifo_empty_o;
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    if (bit_cnt_q == nbits_q - 1'b1) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    // Final stop period: the next frame, if queued, follows with no idle gap.
                    if (stop_cnt_q == two_stop_q) begin
                        done_c = 1'b1;
                        if (!tx_fifo_empty_o) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        if (pop) begin
            state_d    = START;
            tx_d       = 1'b0;
            shift_d    = fifo_head;
            nbits_d    = cfg_nbits;
            par_en_d   = cfg_par_en;
            par_bit_d  = cfg_par_bit;
            two_stop_d = cfg_two_stop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= CW'(DATA_WIDTH);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_c & ~rst_i;

endmodule
